uart_rx_framer: RTL and testbench
=================================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PARITY_EN, default 1, enables one parity bit after the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Rx_EN  input  1  receiver enable.
REQ-007 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port sample_ENABLE  input  1  one-clk pulse at 16x baud from the receiver baud controller.
REQ-009 SHALL have port Rx_DATA  output  8  received data, LSB-aligned, unused MSBs 0.
REQ-010 SHALL have port Rx_VALID  output  1  one-clk pulse, frame complete.
REQ-011 SHALL have port Rx_FERROR  output  1  framing error of the last frame.
REQ-012 SHALL have port Rx_PERROR  output  1  parity error of the last frame.

Function
REQ-013 SHALL pass RxD through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-014 SHALL keep a 4-bit sample index (0..15), advanced only on sample_ENABLE, wrapping 15->0.
REQ-015 SHALL decide each bit by majority of the synchronized line at sample indices 7, 8 and 9; the decision SHALL be taken on the index-9 tick.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: on a tick with the synchronized line at 0, SHALL go to START with the index set to 0 for that tick.
REQ-018 START: if the majority at index 9 is 1 (false start), SHALL return to IDLE with no output change; otherwise SHALL go to DATA on the index-15 tick.
REQ-019 DATA: SHALL shift bits in LSB-first and count DATA_BITS bits; after the last bit's index-15 tick SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY: SHALL compare the sampled bit with the XOR of the data bits (inverted when PARITY_ODD=1); it SHALL go to STOP on the index-15 tick.
REQ-021 STOP: on the index-9 tick SHALL set Rx_FERROR=1 if the majority is 0, else 0, and return to IDLE immediately without waiting for index 15.
REQ-022 On the STOP index-9 tick SHALL register Rx_DATA, Rx_FERROR and Rx_PERROR (PERROR forced 0 when PARITY_EN=0) and pulse Rx_VALID high for exactly the next clk cycle.
REQ-023 Rx_DATA and both error flags SHALL hold their value until the next Rx_VALID; a frame with errors SHALL still assert Rx_VALID.
REQ-024 Without sample_ENABLE the state, index and shift register SHALL not change, except for the synchronizer.
REQ-025 Rx_EN=0 SHALL force IDLE and suppress Rx_VALID; held outputs SHALL be kept; a frame in progress SHALL be discarded.
REQ-026 A falling edge during STOP before index 9 SHALL be ignored; a start bit SHALL be detectable from the tick after the STOP decision.

Reset
REQ-027 reset=1 SHALL force IDLE, index 0, shift register 0, bit counter 0, synchronizer flops 1, Rx_DATA=0, Rx_VALID=0, Rx_FERROR=0, Rx_PERROR=0 at the next clk edge, including mid-frame.
REQ-028 reset SHALL take priority over Rx_EN, sample_ENABLE and RxD.

Verification
REQ-029 Defaults, 0xA5 sent with parity 0 and stop 1, 16 ticks per bit -> one Rx_VALID pulse, Rx_DATA=0xA5, FERROR=0, PERROR=0.
REQ-030 0xA5 sent with parity 1 -> Rx_DATA=0xA5, PERROR=1; stop bit 0 -> FERROR=1, Rx_VALID still pulses.
REQ-031 RxD low for 3 ticks then high -> no Rx_VALID, outputs unchanged, next valid frame 0x3C received correctly.
REQ-032 Single-tick glitch at index 8 of data bit 2 of 0xFF -> Rx_DATA=0xFF (majority vote).
REQ-033 reset asserted during data bit 4 -> all outputs 0 next cycle, no Rx_VALID; following frame 0x81 received correctly.
REQ-034 Back-to-back frames 0x00 then 0xFF, next start bit directly after the stop bit -> two Rx_VALID pulses with the data in order and no errors.

Source files
------------

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronizes the serial line, oversamples each bit at
// 16 ticks per bit with a 3-sample majority vote, and delivers one frame
// (start, DATA_BITS data LSB-first, optional parity, stop) per Rx_VALID pulse.
module uart_rx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic       RxD,
  input  logic       sample_ENABLE,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR
);

  localparam logic       HAS_PAR  = (PARITY_EN != 0);
  localparam logic       ODD      = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [3:0]             idx, idx_next;
  logic                   rxd_p0, rxd_p1;
  logic                   s7, s8;
  logic                   maj;
  logic [DATA_BITS-1:0]   shreg;
  logic [2:0]             cnt;
  logic                   par_err;

  // Majority of the samples taken at indices 7, 8 and the current (index 9) one.
  assign maj = (s7 & s8) | (s7 & rxd_p1) | (s8 & rxd_p1);

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RxD;
      rxd_p1 <= rxd_p0;
    end
  end

  // Frame state and sample index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next state and next sample index; the tick that sees the start edge is index 0.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (!Rx_EN) begin
      state_next = IDLE;
      idx_next   = 4'd0;
    end else if (sample_ENABLE) begin
      idx_next = idx + 4'd1;
      case (state)
        IDLE: begin
          idx_next = 4'd0;
          if (!rxd_p1) begin
            state_next = START;
            idx_next   = 4'd1;
          end
        end
        START: begin
          if (idx == 4'd9 && maj) begin
            state_next = IDLE;
            idx_next   = 4'd0;
          end else if (idx == 4'd15) begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (idx == 4'd15 && cnt == LAST_BIT)
            state_next = HAS_PAR ? PARITY : STOP;
        end
        PARITY: begin
          if (idx == 4'd15)
            state_next = STOP;
        end
        STOP: begin
          if (idx == 4'd9) begin
            state_next = IDLE;
            idx_next   = 4'd0;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = 4'd0;
        end
      endcase
    end
  end

  // Sampling, data shift, parity check and registered frame results.
  always_ff @(posedge clk) begin
    if (reset) begin
      s7        <= 1'b1;
      s8        <= 1'b1;
      shreg     <= '0;
      cnt       <= 3'd0;
      par_err   <= 1'b0;
      Rx_DATA   <= 8'd0;
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_PERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      if (!Rx_EN) begin
        cnt <= 3'd0;
      end else if (sample_ENABLE) begin
        if (idx == 4'd7) s7 <= rxd_p1;
        if (idx == 4'd8) s8 <= rxd_p1;
        case (state)
          DATA: begin
            if (idx == 4'd9)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (idx == 4'd15)
              cnt <= (cnt == LAST_BIT) ? 3'd0 : cnt + 3'd1;
          end
          PARITY: begin
            if (idx == 4'd9)
              par_err <= maj ^ (^shreg) ^ ODD;
          end
          STOP: begin
            if (idx == 4'd9) begin
              Rx_DATA   <= 8'(shreg);
              Rx_FERROR <= ~maj;
              Rx_PERROR <= HAS_PAR & par_err;
              Rx_VALID  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: frames are described bit by bit in tick units,
// expected results are derived from the frame contents and tick arithmetic.
module tb_uart_rx_framer;

  localparam int DB   = 8;
  localparam int PEN  = 1;
  localparam int PODD = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic       sample_ENABLE = 1'b0;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         tick;
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q[$];
  int   stim_ticks = 0;
  int   seen_ticks = 0;

  logic [7:0] m_data = 8'd0;
  logic       m_fe = 1'b0;
  logic       m_pe = 1'b0;
  logic       c_r, c_t, c_v;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .DATA_BITS (DB),
    .PARITY_EN (PEN),
    .PARITY_ODD(PODD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rx_EN        (Rx_EN),
    .RxD          (RxD),
    .sample_ENABLE(sample_ENABLE),
    .Rx_DATA      (Rx_DATA),
    .Rx_VALID     (Rx_VALID),
    .Rx_FERROR    (Rx_FERROR),
    .Rx_PERROR    (Rx_PERROR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] d, input logic fe, input logic pe);
    check({name, "_data"}, {24'd0, Rx_DATA}, {24'd0, d});
    check({name, "_ferr"}, {31'd0, Rx_FERROR}, {31'd0, fe});
    check({name, "_perr"}, {31'd0, Rx_PERROR}, {31'd0, pe});
  endtask

  // Per-cycle comparison of the outputs against the expected frame list.
  initial begin
    forever begin
      @(posedge clk);
      c_r = reset;
      c_t = sample_ENABLE;
      #1;
      if (c_t) seen_ticks++;
      c_v = 1'b0;
      if (c_r) begin
        m_data = 8'd0;
        m_fe   = 1'b0;
        m_pe   = 1'b0;
      end else if (c_t && q.size() > 0 && q[0].tick == seen_ticks) begin
        c_v    = 1'b1;
        m_data = q[0].data;
        m_fe   = q[0].fe;
        m_pe   = q[0].pe;
        void'(q.pop_front());
      end
      check("cyc_valid", {31'd0, Rx_VALID}, {31'd0, c_v});
      check("cyc_held", {22'd0, Rx_DATA, Rx_FERROR, Rx_PERROR}, {22'd0, m_data, m_fe, m_pe});
    end
  end

  // One line tick: level applied, optional reset/disable pulse, then the tick.
  task automatic do_tick(input logic level, input int ctl);
    @(negedge clk);
    RxD = level;
    sample_ENABLE = 1'b0;
    if (ctl == 1) reset = 1'b1;
    else if (ctl == 2) Rx_EN = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    Rx_EN = 1'b1;
    repeat (2) @(negedge clk);
    stim_ticks++;
    sample_ENABLE = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1, 0);
  endtask

  // Sends one frame; g_bit/g_idx place a one-tick glitch, a_bit/a_ctl abort it.
  task automatic send_frame(input logic [7:0] data, input bit par_flip, input bit stop_bad,
                            input int stop_len, input int g_bit, input int g_idx,
                            input int a_bit, input int a_ctl);
    logic lv[12];
    int   nb;
    int   len;
    logic level;
    logic par;
    nb = 2 + DB + PEN;
    par = (($countones(data) % 2) != 0);
    lv[0] = 1'b0;
    for (int i = 0; i < DB; i++) lv[1+i] = data[i];
    if (PEN != 0) lv[1+DB] = par ^ (PODD != 0) ^ par_flip;
    lv[nb-1] = ~stop_bad;
    if (a_ctl == 0)
      q.push_back('{stim_ticks + 1 + 16 * (nb - 1) + 9, data, stop_bad, (PEN != 0) && par_flip});
    for (int b = 0; b < nb; b++) begin
      len = (b == nb - 1) ? stop_len : 16;
      for (int i = 0; i < len; i++) begin
        level = lv[b];
        if (b == g_bit && i == g_idx) level = ~level;
        if (a_ctl != 0 && b == a_bit && i == 4) begin
          do_tick(1'b1, a_ctl);
          return;
        end
        do_tick(level, 0);
      end
    end
  endtask

  initial begin
    int nb;
    logic [7:0] d;
    bit flip, bad;
    int sl, gb, gi;
    nb = 2 + DB + PEN;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_out("reset", 8'h00, 1'b0, 1'b0);
    check("reset_valid", {31'd0, Rx_VALID}, 32'd0);
    reset = 1'b0;
    idle(3);

    send_frame(8'hA5, 0, 0, 16, -1, 0, -1, 0);
    idle(2);
    check_out("a5_ok", 8'hA5, 1'b0, 1'b0);

    send_frame(8'hA5, 1, 0, 16, -1, 0, -1, 0);
    idle(2);
    check_out("a5_perr", 8'hA5, 1'b0, 1'b1);

    send_frame(8'hA5, 0, 1, 10, -1, 0, -1, 0);
    idle(2);
    check_out("a5_ferr", 8'hA5, 1'b1, 1'b0);

    repeat (3) do_tick(1'b0, 0);
    idle(12);
    check_out("false_start", 8'hA5, 1'b1, 1'b0);

    send_frame(8'h3C, 0, 0, 16, -1, 0, -1, 0);
    idle(2);
    check_out("x3c", 8'h3C, 1'b0, 1'b0);

    send_frame(8'hFF, 0, 0, 16, 3, 8, -1, 0);
    idle(2);
    check_out("glitch_ff", 8'hFF, 1'b0, 1'b0);

    send_frame(8'h55, 0, 0, 16, -1, 0, 5, 1);
    idle(2);
    check_out("mid_reset", 8'h00, 1'b0, 1'b0);

    send_frame(8'h81, 0, 0, 16, -1, 0, -1, 0);
    idle(2);
    check_out("x81", 8'h81, 1'b0, 1'b0);

    send_frame(8'hC3, 0, 0, 16, -1, 0, 3, 2);
    idle(2);
    check_out("rx_en_drop", 8'h81, 1'b0, 1'b0);

    send_frame(8'h00, 0, 0, 16, -1, 0, -1, 0);
    send_frame(8'hFF, 0, 0, 16, -1, 0, -1, 0);
    idle(2);
    check_out("b2b", 8'hFF, 1'b0, 1'b0);

    repeat (25) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      bad  = ($urandom_range(0, 4) == 0);
      sl   = bad ? 10 : int'($urandom_range(10, 16));
      gb   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, nb - 1));
      gi   = (gb == nb - 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
      send_frame(d, flip, bad, sl, gb, gi, -1, 0);
      idle(int'($urandom_range(0, 3)));
    end

    idle(4);
    check("frames_drained", q.size(), 32'd0);
    @(negedge clk);
    sample_ENABLE = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
